// File: rtl/gelu_lane_arbiter_if.sv
// Bundle between vector requesters, the round-robin lane arbiter and the shared GELU datapath.
// The master side drives requests and the datapath return; the slave side is the arbiter.
interface gelu_lane_arbiter_if #(
  parameter int NUM_REQ          = 2,
  parameter int BUS_NUM          = 16,
  parameter int FIXED_DATA_WIDTH = 8
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = BUS_NUM * FIXED_DATA_WIDTH;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*BEAT_W-1:0]  req_data;
  logic [NUM_REQ*BUS_NUM-1:0] req_lane_vld;
  logic [NUM_REQ-1:0]         req_ready;
  logic [BEAT_W-1:0]          act_in_data;
  logic [BUS_NUM-1:0]         act_in_vld;
  logic [BEAT_W-1:0]          act_out_data;
  logic [BUS_NUM-1:0]         act_out_vld;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic                       rsp_last;
  logic [BEAT_W-1:0]          rsp_data;
  logic [BUS_NUM-1:0]         rsp_lane_vld;
  logic                       busy;

  modport master (
    output req_valid, req_last, req_data, req_lane_vld, act_out_data, act_out_vld,
    input  req_ready, act_in_data, act_in_vld, rsp_valid, rsp_id, rsp_last,
           rsp_data, rsp_lane_vld, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, req_lane_vld, act_out_data, act_out_vld,
    output req_ready, act_in_data, act_in_vld, rsp_valid, rsp_id, rsp_last,
           rsp_data, rsp_lane_vld, busy
  );
endinterface

// File: rtl/gelu_lane_arbiter.sv
// Round-robin arbiter sharing one lane-parallel GELU datapath among NUM_REQ requesters,
// with an owner/last tag pipe matching the datapath latency to route results back.
module gelu_lane_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int BUS_NUM          = 16,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int ACT_LATENCY      = 1,
  parameter int BURST_MAX        = 4
) (
  input logic             clk,
  input logic             rst_n,
  gelu_lane_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = BUS_NUM * FIXED_DATA_WIDTH;
  localparam int CNT_W  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int TAIL   = ACT_LATENCY - 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]  last_owner, last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]  pick, idx;
  logic             found;
  logic             accept, acc_last;

  logic [ACT_LATENCY-1:0] tag_vld_p;
  logic [ID_W-1:0]        tag_id_p   [ACT_LATENCY];
  logic                   tag_last_p [ACT_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    last_owner_nxt   = last_owner;
    beat_cnt_nxt     = beat_cnt;
    bus.req_ready    = '0;
    bus.act_in_data  = '0;
    bus.act_in_vld   = '0;
    accept           = 1'b0;
    acc_last         = 1'b0;
    pick             = '0;
    idx              = '0;
    found            = 1'b0;
    // Search starts just after the previous owner, so a regrant to it comes last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_owner) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        bus.req_ready = NUM_REQ'(1) << grant;
        accept        = bus.req_valid[grant];
        if (accept) begin
          bus.act_in_data = bus.req_data[int'(grant)*BEAT_W +: BEAT_W];
          bus.act_in_vld  = bus.req_lane_vld[int'(grant)*BUS_NUM +: BUS_NUM];
          acc_last        = bus.req_last[grant];
          beat_cnt_nxt    = beat_cnt + 1'b1;
          if (acc_last || beat_cnt == CNT_W'(BURST_MAX - 1)) begin
            last_owner_nxt = grant;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag pipe stage 0 .. ACT_LATENCY-1, aligned with the datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      for (int s = 0; s < ACT_LATENCY; s++) begin
        tag_id_p[s]   <= '0;
        tag_last_p[s] <= 1'b0;
      end
    end else begin
      tag_vld_p[0]  <= accept;
      tag_id_p[0]   <= grant;
      tag_last_p[0] <= acc_last;
      for (int s = 1; s < ACT_LATENCY; s++) begin
        tag_vld_p[s]  <= tag_vld_p[s-1];
        tag_id_p[s]   <= tag_id_p[s-1];
        tag_last_p[s] <= tag_last_p[s-1];
      end
    end
  end

  assign bus.rsp_valid    = tag_vld_p[TAIL];
  assign bus.rsp_id       = tag_vld_p[TAIL] ? tag_id_p[TAIL] : '0;
  assign bus.rsp_last     = tag_vld_p[TAIL] & tag_last_p[TAIL];
  assign bus.rsp_data     = bus.act_out_data;
  assign bus.rsp_lane_vld = bus.act_out_vld;
  assign bus.busy         = (state == BUSY) || (|tag_vld_p);
endmodule
